// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct3 codes, FSM states and latency constants for muldiv_seq
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int DIV_STEPS = 32;
    localparam int MUL_LAT   = 2;
    localparam int DIV_LAT   = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq_mul33.sv
// rtl/muldiv_seq_mul33.sv - combinational signed 33x33 -> 66 multiplier (module mul33)
module mul33 (
    input  logic signed [32:0] a,
    input  logic signed [32:0] b,
    output logic signed [65:0] p
);

    assign p = a * b;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multi-cycle multiply/divide sequencer
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;
    logic [XLEN-1:0] result_q, result_d;

    logic signed [XLEN:0]     a_ext, b_ext;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN:0]            rem_sh;
    logic [XLEN+1:0]          diff;
    logic [XLEN-1:0]          quo_fix, rem_fix, a_abs, b_abs;
    logic                     sgn;
    logic                     early_hit;
    logic [XLEN-1:0]          early_val;
    logic                     unused_bits;

    // MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed
    assign a_ext = {(op_q != F3_MULHU) & a_q[XLEN-1], a_q};
    assign b_ext = {((op_q == F3_MUL) || (op_q == F3_MULH)) & b_q[XLEN-1], b_q};

    mul33 u_mul (
        .a (a_ext),
        .b (b_ext),
        .p (prod)
    );

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign quo_fix = dvz_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    assign sgn   = ~funct3[0];
    assign a_abs = (sgn & rs1[XLEN-1]) ? -rs1 : rs1;
    assign b_abs = (sgn & rs2[XLEN-1]) ? -rs2 : rs2;

    // diff[XLEN] is always 0 when the difference is kept; product sign bits are redundant
    assign unused_bits = ^{prod[2*XLEN+1:2*XLEN], diff[XLEN]};

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        early_hit = 1'b0;
        early_val = '0;
        if (rs2 == '0) begin
            early_hit = 1'b1;
            early_val = funct3[1] ? rs1 : '1;
        end else if (sgn && (rs1 == INT_MIN) && (rs2 == '1)) begin
            early_hit = 1'b1;
            early_val = funct3[1] ? '0 : INT_MIN;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_val = INT_MIN;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvz_d    = dvz_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    op_d = funct3;
                    a_d  = rs1;
                    b_d  = rs2;
                    if (!funct3[2]) begin
                        state_d = ST_MUL;
                    end else if (early_hit) begin
                        result_d = early_val;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        rem_d   = '0;
                        cnt_d   = 5'(DIV_STEPS - 1);
                        qneg_d  = sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        rneg_d  = sgn & rs1[XLEN-1];
                        dvz_d   = (rs2 == '0);
                    end
                end
            end
            ST_MUL: begin
                result_d = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
                rem_d = diff[XLEN+1] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvz_q    <= dvz_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard testbench for muldiv_seq
module tb_muldiv_seq;

    localparam int MLAT = 2;
    localparam int DLAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] last_res = '0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every done must match the oldest outstanding expectation, value and cycle
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done cyc=%0d result=%h required no done", cyc, result);
            end else begin
                logic [31:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                if (result !== e || cyc != ec) begin
                    n_fail++;
                    $display("FAIL done_result got %h at cyc %0d, required %h at cyc %0d",
                             result, cyc, e, ec);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // caller is at a negedge; start is driven in that cycle (cycle 0)
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat);
        bit bad;
        start  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + lat);
        last_res = e;
        @(negedge clk);
        start = 1'b0;
        bad   = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_window f3=%0d gap=%b busy_after=%b required high for cycles 1..%0d then low",
                     f, bad, busy, lat);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MLAT);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MLAT);
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MLAT);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DLAT);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DLAT);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       DLAT);
        run_op(3'b111, 32'd100,      32'd7,        32'd2,        DLAT);
        run_op(3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, DLAT);
        run_op(3'b110, 32'd20,       32'hFFFFFFFA, 32'd2,        DLAT);
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SLAT);
        run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, SLAT);
        run_op(3'b110, 32'd5,        32'd0,        32'd5,        SLAT);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SLAT);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SLAT);
        run_op(3'b111, 32'h80000000, 32'd3,        32'd2,        DLAT);

        // kill at cycle 10 of a DIV; a MUL started at cycle 11 finishes at cycle 13
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_result_held", result, last_res);
        run_op(3'b000, 32'd12, 32'd11, 32'd132, MLAT);

        // async reset at cycle 5 of a DIV
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd77; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // start held through busy with different operands is ignored
        exp_q.push_back(32'd42);
        cyc_q.push_back(cyc + MLAT);
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7;
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held_start_idle", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done outstanding=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
